// File: rtl/init_command_sequencer.sv
// 8259A initialization/operation command sequencer: walks ICW1..ICW4, then
// decodes OCW1..OCW3 into held configuration registers and one-cycle pulses.
module init_command_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       write_strobe,
  input  logic       address,
  input  logic [7:0] internal_data_bus,
  output logic       init_busy,
  output logic       level_triggered,
  output logic       single_mode,
  output logic [4:0] vector_base,
  output logic [7:0] cascade_config,
  output logic       microprocessor_mode,
  output logic       auto_eoi,
  output logic       buffer_master,
  output logic       buffered_mode,
  output logic       special_fully_nested,
  output logic [7:0] interrupt_mask,
  output logic       ocw2_pulse,
  output logic [2:0] ocw2_command,
  output logic [2:0] ocw2_level,
  output logic       read_isr_select,
  output logic       special_mask_mode,
  output logic       poll_pulse
);

  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } state_t;

  state_t state;
  logic   icw4_needed;
  logic   is_icw1;

  assign is_icw1 = ~address & internal_data_bus[4];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= READY;
      icw4_needed          <= 1'b0;
      init_busy            <= 1'b0;
      level_triggered      <= 1'b0;
      single_mode          <= 1'b0;
      vector_base          <= 5'd0;
      cascade_config       <= 8'h00;
      microprocessor_mode  <= 1'b0;
      auto_eoi             <= 1'b0;
      buffer_master        <= 1'b0;
      buffered_mode        <= 1'b0;
      special_fully_nested <= 1'b0;
      interrupt_mask       <= 8'h00;
      ocw2_pulse           <= 1'b0;
      ocw2_command         <= 3'd0;
      ocw2_level           <= 3'd0;
      read_isr_select      <= 1'b0;
      special_mask_mode    <= 1'b0;
      poll_pulse           <= 1'b0;
    end else begin
      ocw2_pulse <= 1'b0;
      poll_pulse <= 1'b0;
      if (write_strobe) begin
        if (is_icw1) begin
          // ICW1 restarts from any state and wipes ICW4/OCW-derived settings
          level_triggered      <= internal_data_bus[3];
          single_mode          <= internal_data_bus[1];
          icw4_needed          <= internal_data_bus[0];
          interrupt_mask       <= 8'h00;
          special_mask_mode    <= 1'b0;
          read_isr_select      <= 1'b0;
          microprocessor_mode  <= 1'b0;
          auto_eoi             <= 1'b0;
          buffer_master        <= 1'b0;
          buffered_mode        <= 1'b0;
          special_fully_nested <= 1'b0;
          state                <= WAIT_ICW2;
          init_busy            <= 1'b1;
        end else begin
          unique case (state)
            READY: begin
              if (address) begin
                interrupt_mask <= internal_data_bus;
              end else if (!internal_data_bus[3]) begin
                ocw2_command <= internal_data_bus[7:5];
                ocw2_level   <= internal_data_bus[2:0];
                ocw2_pulse   <= 1'b1;
              end else begin
                if (internal_data_bus[1]) read_isr_select   <= internal_data_bus[0];
                if (internal_data_bus[6]) special_mask_mode <= internal_data_bus[5];
                poll_pulse <= internal_data_bus[2];
              end
            end
            WAIT_ICW2: begin
              if (address) begin
                vector_base <= internal_data_bus[7:3];
                if (!single_mode) begin
                  state <= WAIT_ICW3;
                end else if (icw4_needed) begin
                  state <= WAIT_ICW4;
                end else begin
                  state     <= READY;
                  init_busy <= 1'b0;
                end
              end
            end
            WAIT_ICW3: begin
              if (address) begin
                cascade_config <= internal_data_bus;
                if (icw4_needed) begin
                  state <= WAIT_ICW4;
                end else begin
                  state     <= READY;
                  init_busy <= 1'b0;
                end
              end
            end
            WAIT_ICW4: begin
              if (address) begin
                microprocessor_mode  <= internal_data_bus[0];
                auto_eoi             <= internal_data_bus[1];
                buffer_master        <= internal_data_bus[2];
                buffered_mode        <= internal_data_bus[3];
                special_fully_nested <= internal_data_bus[4];
                state                <= READY;
                init_busy            <= 1'b0;
              end
            end
            default: state <= READY;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_init_command_sequencer.sv
// Bench for init_command_sequencer: directed protocol scenarios plus random
// writes, all compared against a queue-based model of the pending ICW steps.
module tb_init_command_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       write_strobe;
  logic       address;
  logic [7:0] internal_data_bus;
  logic       init_busy, level_triggered, single_mode;
  logic [4:0] vector_base;
  logic [7:0] cascade_config;
  logic       microprocessor_mode, auto_eoi, buffer_master, buffered_mode, special_fully_nested;
  logic [7:0] interrupt_mask;
  logic       ocw2_pulse;
  logic [2:0] ocw2_command, ocw2_level;
  logic       read_isr_select, special_mask_mode, poll_pulse;

  init_command_sequencer dut (
    .clock(clock), .reset(reset), .write_strobe(write_strobe), .address(address),
    .internal_data_bus(internal_data_bus), .init_busy(init_busy),
    .level_triggered(level_triggered), .single_mode(single_mode),
    .vector_base(vector_base), .cascade_config(cascade_config),
    .microprocessor_mode(microprocessor_mode), .auto_eoi(auto_eoi),
    .buffer_master(buffer_master), .buffered_mode(buffered_mode),
    .special_fully_nested(special_fully_nested), .interrupt_mask(interrupt_mask),
    .ocw2_pulse(ocw2_pulse), .ocw2_command(ocw2_command), .ocw2_level(ocw2_level),
    .read_isr_select(read_isr_select), .special_mask_mode(special_mask_mode),
    .poll_pulse(poll_pulse)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: pending ICW steps (2,3,4) kept as a queue.
  int         m_pending[$];
  logic       m_lt, m_sn;
  logic [4:0] m_vb, m_icw4;
  logic [7:0] m_cas, m_mask;
  logic [2:0] m_cmd, m_lvl;
  logic       m_p2, m_poll, m_ris, m_smm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pending.delete();
    m_lt = 0; m_sn = 0; m_vb = 0; m_icw4 = 0; m_cas = 0; m_mask = 0;
    m_cmd = 0; m_lvl = 0; m_p2 = 0; m_poll = 0; m_ris = 0; m_smm = 0;
  endtask

  task automatic model_write(input logic s, input logic a, input logic [7:0] d);
    int stepn;
    m_p2 = 0;
    m_poll = 0;
    if (!s) return;
    if (!a && d[4]) begin
      m_lt = d[3]; m_sn = d[1];
      m_mask = 0; m_smm = 0; m_ris = 0; m_icw4 = 0;
      m_pending.delete();
      m_pending.push_back(2);
      if (!d[1]) m_pending.push_back(3);
      if (d[0])  m_pending.push_back(4);
    end else if (m_pending.size() != 0) begin
      if (a) begin
        stepn = m_pending.pop_front();
        if (stepn == 2) m_vb = d[7:3];
        else if (stepn == 3) m_cas = d;
        else m_icw4 = d[4:0];
      end
    end else if (a) begin
      m_mask = d;
    end else if (!d[3]) begin
      m_cmd = d[7:5]; m_lvl = d[2:0]; m_p2 = 1;
    end else begin
      if (d[1]) m_ris = d[0];
      if (d[6]) m_smm = d[5];
      m_poll = d[2];
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".busy"}, init_busy, m_pending.size() != 0);
    chk({ctx, ".ltim"}, level_triggered, m_lt);
    chk({ctx, ".sngl"}, single_mode, m_sn);
    chk({ctx, ".vbase"}, vector_base, m_vb);
    chk({ctx, ".cas"}, cascade_config, m_cas);
    chk({ctx, ".icw4"}, {special_fully_nested, buffered_mode, buffer_master,
                         auto_eoi, microprocessor_mode}, m_icw4);
    chk({ctx, ".mask"}, interrupt_mask, m_mask);
    chk({ctx, ".p2"}, ocw2_pulse, m_p2);
    chk({ctx, ".cmd"}, ocw2_command, m_cmd);
    chk({ctx, ".lvl"}, ocw2_level, m_lvl);
    chk({ctx, ".ris"}, read_isr_select, m_ris);
    chk({ctx, ".smm"}, special_mask_mode, m_smm);
    chk({ctx, ".poll"}, poll_pulse, m_poll);
  endtask

  // One clock cycle: drive at negedge, model the edge, check just after it.
  task automatic cyc(input string ctx, input logic s, input logic a, input logic [7:0] d);
    @(negedge clock);
    write_strobe = s;
    address = a;
    internal_data_bus = d;
    model_write(s, a, d);
    @(posedge clock);
    #1;
    check_all(ctx);
  endtask

  task automatic wr(input string ctx, input logic a, input logic [7:0] d);
    cyc(ctx, 1'b1, a, d);
  endtask

  task automatic idle(input string ctx);
    cyc(ctx, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic s, a;
    logic [7:0] d;
    reset = 1'b1;
    write_strobe = 1'b0;
    address = 1'b0;
    internal_data_bus = 8'h00;
    model_reset();
    #12;
    check_all("rst");
    @(negedge clock);
    reset = 1'b0;
    idle("post_rst");

    // Full cascade init, back-to-back
    wr("cas1", 0, 8'h11); chk("cas1_busy", init_busy, 1);
    wr("cas2", 1, 8'h48); chk("cas2_busy", init_busy, 1);
    wr("cas3", 1, 8'h04); chk("cas3_busy", init_busy, 1);
    wr("cas4", 1, 8'h03);
    chk("cas_busy_done", init_busy, 0);
    chk("cas_vb", vector_base, 5'h09);
    chk("cas_cc", cascade_config, 8'h04);
    chk("cas_aeoi", auto_eoi, 1);
    chk("cas_upm", microprocessor_mode, 1);

    // Single, no ICW4
    wr("sng1", 0, 8'h1A);
    wr("sng2", 1, 8'h20);
    chk("sng_busy", init_busy, 0);
    chk("sng_lt", level_triggered, 1);
    chk("sng_sn", single_mode, 1);
    chk("sng_vb", vector_base, 5'h04);
    chk("sng_icw4", {special_fully_nested, buffered_mode, buffer_master, auto_eoi,
                     microprocessor_mode}, 5'd0);
    wr("sng_ocw1", 1, 8'hF0);
    chk("sng_mask", interrupt_mask, 8'hF0);

    // OCW2 / OCW3
    wr("ocw2", 0, 8'h63);
    chk("ocw2_p", ocw2_pulse, 1);
    chk("ocw2_cmd", ocw2_command, 3'b011);
    chk("ocw2_lvl", ocw2_level, 3'd3);
    idle("ocw2_gap");
    chk("ocw2_p_off", ocw2_pulse, 0);
    wr("ocw3a", 0, 8'h0B);
    chk("ocw3_ris", read_isr_select, 1);
    wr("ocw3b", 0, 8'h6C);
    chk("ocw3_smm", special_mask_mode, 1);
    chk("ocw3_poll", poll_pulse, 1);
    wr("ocw2_b2b", 0, 8'h25);
    wr("ocw2_b2b2", 0, 8'hE7);
    idle("poll_off");

    // Ignored writes
    wr("ign_icw1", 0, 8'h11);
    wr("ign_disc", 0, 8'h20);
    chk("ign_busy", init_busy, 1);
    chk("ign_p2", ocw2_pulse, 0);
    for (int i = 0; i < 4; i++) cyc("ign_nostb", 0, i[0], 8'($urandom));
    wr("ign_icw2", 1, 8'h48);
    chk("ign_still", init_busy, 1);

    // ICW1 restart with SNGL=1 IC4=1
    wr("rs1", 0, 8'h13);
    chk("rs_mask", interrupt_mask, 8'h00);
    chk("rs_busy", init_busy, 1);
    wr("rs2", 1, 8'h50);
    chk("rs_wait4", init_busy, 1);
    chk("rs_vb", vector_base, 5'h0A);
    chk("rs_cas_kept", cascade_config, 8'h04);
    wr("rs4", 1, 8'h1F);
    chk("rs_done", init_busy, 0);

    // Async reset in WAIT_ICW3
    wr("ar1", 0, 8'h11);
    wr("ar2", 1, 8'h48);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("ar_async");
    chk("ar_vb0", vector_base, 5'd0);
    @(negedge clock);
    reset = 1'b0;
    wr("ar_ocw1", 1, 8'h55);
    chk("ar_mask", interrupt_mask, 8'h55);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 9) < 7);
      a = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      d[4] = ($urandom_range(0, 3) == 0);
      cyc("rnd", s, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
